bram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 8192 x 64-bit boot/scratch BRAM. It shares the BRAM between two requesters (port 0, port 1) with round-robin arbitration and a one-transaction-at-a-time valid/ready front end. It drives the BRAM's enable, address, write data and byte-enable pins. Because the BRAM treats any nonzero byte-enable as a full 64-bit write, the arbiter implements true partial writes by read-modify-write.

---
 rtl/bram_arbiter.sv | 151 +++++++++++++++
 tb/tb_bram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-port front end and sequencer for the single-port
// 8192 x 64 boot/scratch BRAM. One transaction is in flight at a time. Partial
// byte writes are done as read-modify-write because the BRAM treats any
// nonzero byte-enable as a full-word write.
//
// Ports:
//   clock, resetn          sole clock, synchronous active-low reset
//   reqN_valid/ready       request handshake, port N (N = 0, 1)
//   reqN_addr/wdata/wmask  word address, write data, byte mask (00 read, FF full write)
//   respN_valid/rdata      one-cycle completion pulse; rdata is 0 for writes
//   bram_*                 BRAM pins; bram_rdata has one-cycle read latency
//   busy                   a transaction is in progress
module bram_arbiter (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [12:0] req0_addr,
    input  logic [63:0] req0_wdata,
    input  logic [7:0]  req0_wmask,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [12:0] req1_addr,
    input  logic [63:0] req1_wdata,
    input  logic [7:0]  req1_wmask,
    output logic        resp0_valid,
    output logic [63:0] resp0_rdata,
    output logic        resp1_valid,
    output logic [63:0] resp1_rdata,
    output logic        bram_en,
    output logic [12:0] bram_addr,
    output logic [63:0] bram_wdata,
    output logic [7:0]  bram_we_perbyte,
    input  logic [63:0] bram_rdata,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        prio;       // port that wins when both are valid
    logic        grant;      // granted port id
    logic        grant_any;
    logic        hs;         // handshake this cycle
    logic [7:0]  sel_wmask;
    logic [12:0] addr_q;
    logic [63:0] wdata_q;    // holds the merged word after CAP on partial writes
    logic [63:0] rdata_q;
    logic [7:0]  wmask_q;
    logic        port_q;
    logic [63:0] merged;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? prio : req1_valid;
        hs        = resetn && (state == IDLE) && grant_any;
        sel_wmask = grant ? req1_wmask : req0_wmask;
    end

    always_comb begin
        merged = '0;
        for (int b = 0; b < 8; b++)
            merged[8*b +: 8] = wmask_q[b] ? wdata_q[8*b +: 8] : bram_rdata[8*b +: 8];
    end

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Request latches, priority pointer and read/merge capture
    always_ff @(posedge clock) begin
        if (!resetn) begin
            prio    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wmask_q <= '0;
            port_q  <= 1'b0;
        end else begin
            if (hs) begin
                addr_q  <= grant ? req1_addr  : req0_addr;
                wdata_q <= grant ? req1_wdata : req0_wdata;
                wmask_q <= sel_wmask;
                port_q  <= grant;
                prio    <= ~grant;
            end
            if (state == CAP) begin
                if (wmask_q == 8'h00) rdata_q <= bram_rdata;
                else                  wdata_q <= merged;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hs) state_nxt = (sel_wmask == 8'hFF) ? WR : RD;
            RD:   state_nxt = CAP;
            CAP:  state_nxt = (wmask_q == 8'h00) ? RESP : WR;
            WR:   state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; everything is forced low while resetn is low so no BRAM write
    // can slip out in a reset cycle.
    always_comb begin
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        resp0_valid     = 1'b0;
        resp1_valid     = 1'b0;
        resp0_rdata     = '0;
        resp1_rdata     = '0;
        bram_en         = 1'b0;
        bram_addr       = '0;
        bram_wdata      = '0;
        bram_we_perbyte = '0;
        busy            = 1'b0;
        if (resetn) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    req0_ready = grant_any && !grant;
                    req1_ready = grant_any &&  grant;
                end
                RD: begin
                    bram_en   = 1'b1;
                    bram_addr = addr_q;
                end
                WR: begin
                    bram_en         = 1'b1;
                    bram_addr       = addr_q;
                    bram_wdata      = wdata_q;
                    bram_we_perbyte = 8'hFF;
                end
                RESP: begin
                    resp0_valid = !port_q;
                    resp1_valid =  port_q;
                    if (wmask_q == 8'h00) begin
                        if (port_q) resp1_rdata = rdata_q;
                        else        resp0_rdata = rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: a behavioural BRAM, plus a reference
// memory/priority model updated from transaction-level rules.
module tb_bram_arbiter;
    logic        clock = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [12:0] req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic [7:0]  req0_wmask, req1_wmask;
    logic        resp0_valid, resp1_valid;
    logic [63:0] resp0_rdata, resp1_rdata;
    logic        bram_en;
    logic [12:0] bram_addr;
    logic [63:0] bram_wdata;
    logic [7:0]  bram_we_perbyte;
    logic [63:0] bram_rdata = '0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [63:0] mem     [0:8191];   // physical BRAM contents
    logic [63:0] ref_mem [0:8191];   // expected contents
    bit          ref_prio;

    bram_arbiter dut (
        .clock(clock), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_we_perbyte(bram_we_perbyte), .bram_rdata(bram_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // BRAM: any nonzero byte-enable writes the whole word; read-first.
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we_perbyte != 8'h00) mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? d[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    task automatic drive(input bit p, input bit v, input logic [12:0] a,
                         input logic [63:0] d, input logic [7:0] m);
        if (!p) begin req0_valid = v; req0_addr = a; req0_wdata = d; req0_wmask = m; end
        else    begin req1_valid = v; req1_addr = a; req1_wdata = d; req1_wmask = m; end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_en"},    bram_en, 0);
        chk({tag, "_resp0"}, resp0_valid, 0);
        chk({tag, "_resp1"}, resp1_valid, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    // One transaction on port p; other port idle. Checks BRAM pin timing,
    // response timing/data and the return to idle.
    task automatic do_txn(input bit p, input logic [12:0] a, input logic [63:0] d,
                          input logic [7:0] m);
        bit          got, partial, en_e, rv;
        int          lat;
        logic [63:0] exp_rd, new_word;
        @(negedge clock);
        drive(p, 1'b1, a, d, m);
        #1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (i > 0) begin @(negedge clock); #1; end
            if ((p ? req1_ready : req0_ready) === 1'b1) got = 1;
        end
        chk("ready_seen", got, 1);
        if (!got) begin drive(p, 1'b0, a, d, m); return; end
        chk("ready_other", p ? req0_ready : req1_ready, 0);
        partial  = (m != 8'h00) && (m != 8'hFF);
        lat      = (m == 8'hFF) ? 2 : (m == 8'h00) ? 3 : 4;
        exp_rd   = (m == 8'h00) ? ref_mem[a] : 64'h0;
        new_word = merge(ref_mem[a], d, m);
        if (m != 8'h00) ref_mem[a] = new_word;
        ref_prio = ~p;
        @(posedge clock);
        #1;
        // scramble the fields after the handshake; they must not matter
        drive(p, 1'b0, 13'($urandom), {$urandom, $urandom}, 8'($urandom));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock); #1;
            en_e = (k == 1) || (partial && k == 3);
            chk("bram_en", bram_en, en_e);
            chk("bram_addr", bram_addr, en_e ? 64'(a) : 64'h0);
            if ((m == 8'hFF && k == 1) || (partial && k == 3)) begin
                chk("bram_we", bram_we_perbyte, 8'hFF);
                chk("bram_wdata", bram_wdata, new_word);
            end else begin
                chk("bram_we", bram_we_perbyte, 8'h00);
            end
            rv = (k == lat);
            chk("resp_own",   p ? resp1_valid : resp0_valid, rv);
            chk("resp_other", p ? resp0_valid : resp1_valid, 0);
            chk("resp_rdata", p ? resp1_rdata : resp0_rdata, rv ? exp_rd : 64'h0);
            chk("busy", busy, 1);
        end
        @(negedge clock); #1;
        idle_checks("post");
    endtask

    initial begin
        logic [63:0] v;
        logic [7:0]  m;
        int          hs_n;
        bit          hs_p, exp_any;
        resetn = 1'b0;
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        for (int i = 0; i < 8192; i++) begin
            v = {$urandom, $urandom};
            mem[i] = v; ref_mem[i] = v;
        end
        mem[13'h0005] = 64'h1122334455667788; ref_mem[13'h0005] = 64'h1122334455667788;
        mem[13'h0010] = 64'h0;                ref_mem[13'h0010] = 64'h0;
        ref_prio = 0;

        // Reset held with both ports valid
        drive(0, 1, 13'h0005, '0, 8'h00);
        drive(1, 1, 13'h0006, '0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_rdy1", req1_ready, 0);
            idle_checks("rst");
        end
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("first_grant0", req0_ready, 1);
        chk("first_grant1", req1_ready, 0);
        @(negedge clock);
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);

        // Directed operations
        do_txn(0, 13'h0005, 64'h0, 8'h00);
        do_txn(1, 13'h1FFF, 64'hDEADBEEFCAFEF00D, 8'hFF);
        do_txn(0, 13'h1FFF, 64'h0, 8'h00);
        do_txn(0, 13'h0010, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        chk("partial_model", ref_mem[13'h0010], 64'h00000000FFFFFFFF);
        do_txn(1, 13'h0010, 64'h0, 8'h00);

        // Round-robin: both ports continuously valid with reads
        @(negedge clock);
        drive(0, 1, 13'h0005, '0, 8'h00);
        drive(1, 1, 13'h1FFF, '0, 8'h00);
        hs_n = -100; hs_p = 0;
        for (int n = 0; n < 24; n++) begin
            if (n > 0) @(negedge clock);
            #1;
            chk("rr_resp0", resp0_valid, (n == hs_n + 3) && !hs_p);
            chk("rr_resp1", resp1_valid, (n == hs_n + 3) &&  hs_p);
            if (n == hs_n + 3)
                chk("rr_rdata", hs_p ? resp1_rdata : resp0_rdata,
                    hs_p ? ref_mem[13'h1FFF] : ref_mem[13'h0005]);
            exp_any = (hs_n < 0) ? (n == 0) : (n == hs_n + 4);
            chk("rr_rdy0", req0_ready, exp_any && !ref_prio);
            chk("rr_rdy1", req1_ready, exp_any &&  ref_prio);
            if (exp_any) begin
                hs_p = ref_prio; hs_n = n; ref_prio = ~ref_prio;
            end
        end
        @(negedge clock);
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       m = 8'h00;
                1:       m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            do_txn(1'($urandom), 13'($urandom_range(0, 15)), {$urandom, $urandom}, m);
        end

        // Reset during CAP of a partial write: no write, no response
        @(negedge clock);
        drive(1, 1, 13'h0020, 64'hA5A5A5A5A5A5A5A5, 8'h3C);
        #1;
        chk("mid_rdy", req1_ready, 1);
        @(posedge clock); #1;
        drive(1, 0, '0, '0, '0);
        @(negedge clock);            // RD
        @(negedge clock);            // CAP
        resetn = 1'b0;
        #1;
        chk("mid_gate_busy", busy, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            idle_checks("mid_rst");
        end
        resetn = 1'b1;
        ref_prio = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            idle_checks("mid_after");
        end
        do_txn(0, 13'h0020, 64'h0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
